// File: rtl/conf_mac_seq_ctrl.sv
// conf_mac_seq_ctrl: sequencer that owns the accumulator and streams operand pairs through an external flop-free MAC
//
// Streams len operand pairs through the external MAC. Each MAC result becomes the next accumulator value.
// The final accumulator is presented on a valid/ready result port.
//
// Optional feature: define CONF_MAC_SEQ_OVF_EN to add the sticky unsigned-wrap flag output ovf.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (0 = reset)
//   start      command pulse, honoured only in IDLE; len and acc_init are latched with it
//   len        element count (0 goes straight to DONE)
//   acc_init   accumulator seed
//   abort      synchronous cancel; wins over every other event and returns to IDLE
//   in_valid   operand pair valid
//   in_ready   operand pair ready (RUN only)
//   in_a/in_b  operand pair
//   mac_a/b/c  MAC inputs; a/b forward the operands in RUN, c always carries the accumulator
//   mac_d      MAC result
//   res_valid  result valid (DONE only)
//   res_ready  result consumer ready
//   res_data   accumulator value
//   ovf        (CONF_MAC_SEQ_OVF_EN) sticky wrap flag for the current command
//   busy       high whenever not IDLE
module conf_mac_seq_ctrl #(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int LEN_BITWIDTH       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_BITWIDTH-1:0]       len,
    input  logic [DATA_PATH_BITWIDTH-1:0] acc_init,
    input  logic                          abort,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
    input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_a,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_b,
    output logic [DATA_PATH_BITWIDTH-1:0] mac_c,
    input  logic [DATA_PATH_BITWIDTH-1:0] mac_d,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] res_data,
`ifdef CONF_MAC_SEQ_OVF_EN
    output logic                          ovf,
`endif
    output logic                          busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [LEN_BITWIDTH-1:0] CNT_ONE = LEN_BITWIDTH'(1);
    state_t                          state_q, state_d;
    logic [DATA_PATH_BITWIDTH-1:0]   acc_q, acc_d;
    logic [LEN_BITWIDTH-1:0]         cnt_q, cnt_d;
    logic [LEN_BITWIDTH-1:0]         len_q, len_d;
    logic                            run;
    logic                            accept;
    logic                            last;
    assign run    = state_q == RUN;
    // An accept coinciding with abort is discarded.
    assign accept = run && in_valid && !abort;
    // cnt never wraps: the command terminates on the len_q-1 accept.
    assign last   = cnt_q == len_q - CNT_ONE;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    len_d   = len;
                    acc_d   = acc_init;
                    cnt_d   = '0;
                    state_d = (len == '0) ? DONE : RUN;
                end
                RUN: if (in_valid) begin
                    acc_d   = mac_d;
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = last ? DONE : RUN;
                end
                DONE:    state_d = res_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end
    assign in_ready  = run;
    assign res_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign res_data  = acc_q;
    assign mac_a     = run ? in_a : '0;
    assign mac_b     = run ? in_b : '0;
    assign mac_c     = acc_q;
`ifdef CONF_MAC_SEQ_OVF_EN
    logic ovf_q, ovf_d;
    // Unsigned wrap shows up as the MAC result falling below its c input.
    always_comb begin
        ovf_d = ovf_q;
        if (abort || (state_q == IDLE && start)) ovf_d = 1'b0;
        else if (accept && mac_d < acc_q) ovf_d = 1'b1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_conf_mac_seq_ctrl.sv
// tb_conf_mac_seq_ctrl: scoreboard bench for conf_mac_seq_ctrl with a truncated-MAC stand-in (NAB=4)
module tb_conf_mac_seq_ctrl;
    localparam int NAB = 4;
    typedef struct {
        logic [15:0] d;
        logic        o;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [15:0] acc_init = '0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [15:0] mac_a, mac_b, mac_c, mac_d;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        busy;
`ifdef CONF_MAC_SEQ_OVF_EN
    logic        ovf;
`endif
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [15:0] pa[0:15];
    logic [15:0] pb[0:15];
    conf_mac_seq_ctrl #(.DATA_PATH_BITWIDTH(16), .LEN_BITWIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .acc_init(acc_init), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef CONF_MAC_SEQ_OVF_EN
        .ovf(ovf),
`endif
        .busy(busy)
    );
    always #5 clk = ~clk;
    // Flop-free truncated MAC: drop NAB LSBs of each operand, multiply, shift back, add c.
    logic [31:0] prod;
    always_comb prod = 32'(mac_a >> NAB) * 32'(mac_b >> NAB);
    assign mac_d = 16'(prod << (2 * NAB)) + mac_c;
    // Reference model: one accumulation step in plain arithmetic.
    function automatic longint term(input logic [15:0] a, input logic [15:0] b);
        return ((longint'(a) / 16) * (longint'(b) / 16) * 256) % 65536;
    endfunction
    function automatic logic [15:0] step(input logic [15:0] acc, input logic [15:0] a, input logic [15:0] b);
        return 16'((longint'(acc) + term(a, b)) % 65536);
    endfunction
    function automatic logic wraps(input logic [15:0] acc, input logic [15:0] a, input logic [15:0] b);
        return (longint'(acc) + term(a, b)) >= 65536;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask
    // Monitor: pops the scoreboard on every result handshake and checks hold stability.
    logic        hold = 1'b0;
    logic [15:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            hold = 1'b0;
        end else begin
            if (hold && res_valid) chk("res_data_stable", 32'(res_data), 32'(held));
            if (res_valid && res_ready) begin
                if (sb.size() == 0) chk("unexpected_result", 32'(res_valid), 32'(0));
                else begin
                    e = sb.pop_front();
                    chk("res_data", 32'(res_data), 32'(e.d));
`ifdef CONF_MAC_SEQ_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.o));
`endif
                end
            end
            hold = res_valid && !res_ready;
            held = res_data;
        end
    end
    // One full command: start, n pairs from pa/pb with stalls, then result backpressure of bp cycles.
    task automatic do_cmd(input int n, input logic [15:0] init, input int stall, input bit rnd, input int bp);
        exp_t        e;
        logic [15:0] acc = init;
        logic        o = 1'b0;
        for (int i = 0; i < n; i++) begin
            o = o | wraps(acc, pa[i], pb[i]);
            acc = step(acc, pa[i], pb[i]);
        end
        e.d = acc;
        e.o = o;
        sb.push_back(e);
        acc = init;
        @(posedge clk); #1;
        start = 1'b1; len = 8'(n); acc_init = init;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(1));
`ifdef CONF_MAC_SEQ_OVF_EN
        chk("ovf_cleared_by_start", 32'(ovf), 32'(0));
`endif
        if (n == 0) chk("zero_len_in_ready", 32'(in_ready), 32'(0));
        for (int i = 0; i < n; i++) begin
            repeat (rnd ? $urandom_range(stall, 0) : stall) begin
                in_valid = 1'b0;
                #1;
                chk("stall_in_ready", 32'(in_ready), 32'(1));
                chk("stall_acc_held", 32'(mac_c), 32'(acc));
                @(posedge clk); #1;
            end
            in_valid = 1'b1; in_a = pa[i]; in_b = pb[i];
            #1;
            chk("run_in_ready", 32'(in_ready), 32'(1));
            chk("run_res_valid", 32'(res_valid), 32'(0));
            chk("run_busy", 32'(busy), 32'(1));
            chk("mac_a_fwd", 32'(mac_a), 32'(pa[i]));
            chk("mac_c_acc", 32'(mac_c), 32'(acc));
            @(posedge clk); #1;
            in_valid = 1'b0;
            acc = step(acc, pa[i], pb[i]);
        end
        chk("done_res_valid", 32'(res_valid), 32'(1));
        chk("done_in_ready", 32'(in_ready), 32'(0));
        chk("done_mac_a_zero", 32'(mac_a), 32'(0));
        repeat (bp) begin
            @(posedge clk); #1;
            chk("bp_res_valid", 32'(res_valid), 32'(1));
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_res_valid", 32'(res_valid), 32'(0));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_res_data", 32'(res_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_mac_a", 32'(mac_a), 32'(0));
`ifdef CONF_MAC_SEQ_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'(0));
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // Basic dot product
        for (int i = 0; i < 3; i++) begin pa[i] = 16'h0030; pb[i] = 16'h0020; end
        do_cmd(3, 16'h0000, 0, 1'b0, 0);
        // Zero length
        do_cmd(0, 16'h00AB, 0, 1'b0, 0);
        // Stalls between pairs and result backpressure
        for (int i = 0; i < 2; i++) begin pa[i] = 16'h0010; pb[i] = 16'h0010; end
        do_cmd(2, 16'h0000, 3, 1'b0, 5);
        // Abort together with start (and a concurrent accept) after one accept
        @(posedge clk); #1;
        start = 1'b1; len = 8'd4; acc_init = 16'h0000;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_a = 16'h0030; in_b = 16'h0020;
        @(posedge clk); #1;
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_in_ready", 32'(in_ready), 32'(0));
        chk("abort_res_valid", 32'(res_valid), 32'(0));
        chk("abort_acc_kept", 32'(res_data), 32'(16'h0600));
        abort = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; start = 1'b0;
        chk("abort_start_idle", 32'(busy), 32'(0));
        pa[0] = 16'h0030; pb[0] = 16'h0020;
        do_cmd(1, 16'h0000, 0, 1'b0, 0);
        // Asynchronous reset mid-RUN after two accepts
        @(posedge clk); #1;
        start = 1'b1; len = 8'd4; acc_init = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_a = 16'h0050; in_b = 16'h0070;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        in_valid = 1'b0;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_in_ready", 32'(in_ready), 32'(0));
        chk("arst_res_data", 32'(res_data), 32'(0));
        chk("arst_mac_a", 32'(mac_a), 32'(0));
        sb.delete();
        @(posedge clk); #1 rst = 1'b1;
        pa[0] = 16'h0100; pb[0] = 16'h0200;
        do_cmd(1, 16'h0007, 0, 1'b0, 0);
        // Accumulator wrap (sets ovf when the feature is built in)
        pa[0] = 16'h0030; pb[0] = 16'h0020;
        do_cmd(1, 16'hFF00, 0, 1'b0, 1);
        // Randomised commands
        for (int k = 0; k < 25; k++) begin
            int n;
            n = $urandom_range(6, 0);
            for (int i = 0; i < n; i++) begin
                pa[i] = 16'($urandom);
                pb[i] = 16'($urandom);
            end
            do_cmd(n, 16'($urandom), 2, 1'b1, $urandom_range(3, 0));
        end
        repeat (2) @(posedge clk);
        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
